// File: rtl/wishbone_debug_master_pkg.sv
// Shared opcodes, response bytes and FSM state encoding for the byte-stream
// to Wishbone debug bridge.
package dbg_bridge_pkg;

  localparam logic [7:0] OP_READ     = 8'h52;
  localparam logic [7:0] OP_WRITE    = 8'h57;

  localparam logic [7:0] RSP_OK      = 8'h4B;
  localparam logic [7:0] RSP_BADOP   = 8'h3F;
  localparam logic [7:0] RSP_TIMEOUT = 8'h21;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP
  } dbg_state_t;

  // Single-byte responses sit in the top byte so the serializer shifts MSB first.
  function automatic logic [31:0] one_byte_rsp(input logic [7:0] b);
    return {b, 24'h000000};
  endfunction

endpackage

// File: rtl/wishbone_debug_master_if.sv
// Classic Wishbone single-cycle bus bundle with initiator and responder views.
interface wishbone_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack);
endinterface

// File: rtl/wishbone_debug_master.sv
// Host byte-stream command decoder that issues single Wishbone reads/writes
// and serializes the response back onto the transmit byte channel.
module wishbone_debug_master
  import dbg_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  wishbone_if.master wishbone,
  output logic       busy,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dbg_state_t       r_state;
  logic             r_is_write;
  logic [1:0]       r_byte_cnt;
  logic [CNT_W-1:0] r_tmo;
  logic [31:0]      r_resp;
  logic [1:0]       r_idx;
  logic             r_cyc;
  logic             r_we;
  logic [31:0]      r_adr;
  logic [3:0]       r_sel;
  logic [31:0]      r_dat_w;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_busy;
  logic             r_overrun;
  logic             w_is_cmd;

  assign w_is_cmd = (rx_data == OP_READ) || (rx_data == OP_WRITE);

  assign wishbone.cyc   = r_cyc;
  assign wishbone.stb   = r_cyc;
  assign wishbone.we    = r_we;
  assign wishbone.adr   = r_adr;
  assign wishbone.sel   = r_sel;
  assign wishbone.dat_w = r_dat_w;
  assign tx_data        = r_tx_data;
  assign tx_valid       = r_tx_valid;
  assign busy           = r_busy;
  assign overrun        = r_overrun;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_is_write <= 1'b0;
      r_byte_cnt <= 2'd0;
      r_tmo      <= '0;
      r_resp     <= 32'h0;
      r_idx      <= 2'd0;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= 32'h0;
      r_sel      <= 4'hF;
      r_dat_w    <= 32'h0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      // Bytes arriving while the bus or the response owns the bridge are lost.
      if (rx_valid && (r_state == BUS || r_state == RESP)) r_overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (rx_valid) begin
            r_busy     <= 1'b1;
            r_byte_cnt <= 2'd0;
            if (w_is_cmd) begin
              r_is_write <= (rx_data == OP_WRITE);
              r_state    <= ADDR;
            end else begin
              r_resp  <= one_byte_rsp(RSP_BADOP);
              r_idx   <= 2'd0;
              r_state <= RESP;
            end
          end
        end

        ADDR: begin
          if (rx_valid) begin
            r_adr      <= {r_adr[23:0], rx_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              if (r_is_write) begin
                r_state <= DATA;
              end else begin
                r_state <= BUS;
                r_cyc   <= 1'b1;
                r_we    <= 1'b0;
                r_tmo   <= '0;
              end
            end
          end
        end

        DATA: begin
          if (rx_valid) begin
            r_dat_w    <= {r_dat_w[23:0], rx_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state <= BUS;
              r_cyc   <= 1'b1;
              r_we    <= 1'b1;
              r_tmo   <= '0;
            end
          end
        end

        BUS: begin
          // Ack wins over the timeout when both land on the same cycle.
          if (wishbone.ack) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= RESP;
            if (r_is_write) begin
              r_resp <= one_byte_rsp(RSP_OK);
              r_idx  <= 2'd0;
            end else begin
              r_resp <= wishbone.dat_r;
              r_idx  <= 2'd3;
            end
          end else if (r_tmo == TMO_LAST) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= RESP;
            r_resp  <= one_byte_rsp(RSP_TIMEOUT);
            r_idx   <= 2'd0;
          end else begin
            r_tmo <= r_tmo + CNT_W'(1);
          end
        end

        RESP: begin
          // tx_valid low here means the first byte has not been presented yet.
          if (!r_tx_valid) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_resp[31:24];
            r_resp     <= {r_resp[23:0], 8'h00};
          end else if (tx_ready) begin
            if (r_idx == 2'd0) begin
              r_tx_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= IDLE;
            end else begin
              r_tx_data <= r_resp[31:24];
              r_resp    <= {r_resp[23:0], 8'h00};
              r_idx     <= r_idx - 2'd1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_debug_master.sv
// Directed bench for the debug bridge: command-level model of expected bus
// transfers and response bytes, compared against the DUT every cycle.
module tb_wishbone_debug_master;
  import dbg_bridge_pkg::*;

  localparam int TMO = 1024;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       overrun;

  wishbone_if wb();

  wishbone_debug_master #(.TIMEOUT_CYCLES(TMO), .CNT_W(11)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .wishbone (wb),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Responder: acks after ack_delay+2 cycles of cyc, or never when ack_en is low.
  logic [31:0] mem [logic [31:0]];
  logic        ack_en = 1'b1;
  int          ack_delay = 0;
  int          wcnt;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wb.ack   <= 1'b0;
      wb.dat_r <= 32'h0;
      wcnt     <= 0;
    end else if (wb.cyc && wb.stb && !wb.ack && ack_en) begin
      if (wcnt == ack_delay) begin
        wb.ack   <= 1'b1;
        wcnt     <= 0;
        wb.dat_r <= wb.we ? 32'h0 : rd(wb.adr);
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wb.ack <= 1'b0;
      if (!wb.cyc) wcnt <= 0;
    end
  end

  // Model state: expected transfers and expected response bytes.
  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    int          len;
  } bus_t;

  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  logic [7:0] got_tx[$];
  int         cyc_starts = 0;
  int         cyc_run = 0;
  int         cur_len = 0;
  int         last_cyc_len = 0;
  int         acc_cnt = 0;

  initial begin : monitor
    bus_t       e;
    logic       cyc_prev;
    logic       prev_stall;
    logic [7:0] prev_data;
    cyc_prev   = 1'b0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc_prev   = 1'b0;
        prev_stall = 1'b0;
        cyc_run    = 0;
      end else begin
        check("stb_eq_cyc", 32'(wb.stb), 32'(wb.cyc));
        if (wb.cyc && !cyc_prev) begin
          cyc_starts++;
          cyc_run = 1;
          if (exp_bus.size() == 0) begin
            check("unexpected_cyc", 32'(wb.cyc), 32'h0);
          end else begin
            e = exp_bus.pop_front();
            cur_len = e.len;
            check("bus_adr", wb.adr, e.adr);
            check("bus_we", 32'(wb.we), 32'(e.we));
            check("bus_sel", 32'(wb.sel), 32'hF);
            if (e.we) check("bus_dat_w", wb.dat_w, e.dat);
          end
        end else if (wb.cyc) begin
          cyc_run++;
        end
        if (!wb.cyc && cyc_prev) begin
          last_cyc_len = cyc_run;
          check("cyc_len", 32'(cyc_run), 32'(cur_len));
        end
        if (wb.ack && wb.cyc && wb.we) mem[wb.adr] = wb.dat_w;
        if (prev_stall && tx_valid) check("tx_stable", 32'(tx_data), 32'(prev_data));
        if (tx_valid && tx_ready) begin
          acc_cnt++;
          got_tx.push_back(tx_data);
          if (exp_tx.size() == 0) check("unexpected_tx", 32'(tx_valid), 32'h0);
          else check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        cyc_prev   = wb.cyc;
      end
    end
  end

  // The bridge holds cyc for at most TMO cycles; the responder needs ack_delay+2.
  task automatic expect_bus(input logic [31:0] a, input logic we, input logic [31:0] d,
                            output logic ok);
    bus_t e;
    int   l;
    l      = ack_en ? ack_delay + 2 : 1 << 30;
    ok     = (l <= TMO);
    e.adr  = a;
    e.we   = we;
    e.dat  = d;
    e.len  = ok ? l : TMO;
    exp_bus.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    logic ok;
    got_tx.delete();
    expect_bus(a, 1'b1, d, ok);
    exp_tx.push_back(ok ? 8'h4B : 8'h21);
    send_byte(8'h57);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic do_read(input logic [31:0] a);
    logic        ok;
    logic [31:0] v;
    got_tx.delete();
    expect_bus(a, 1'b0, 32'h0, ok);
    v = rd(a);
    if (ok) for (int i = 3; i >= 0; i--) exp_tx.push_back(v[i*8 +: 8]);
    else exp_tx.push_back(8'h21);
    send_byte(8'h52);
    for (int i = 3; i >= 1; i--) send_byte(a[i*8 +: 8]);
    check("rd_cyc_before_last", 32'(wb.cyc), 32'h0);
    send_byte(a[7:0]);
    check("rd_cyc_after_last", 32'(wb.cyc), 32'h1);
  endtask

  task automatic do_bad(input logic [7:0] op);
    got_tx.delete();
    exp_tx.push_back(8'h3F);
    send_byte(op);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #1;
      if (!busy && exp_tx.size() == 0 && exp_bus.size() == 0) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'(exp_tx.size() + exp_bus.size()) + 32'(busy), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_bus.delete();
    exp_tx.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] got_word();
    logic [31:0] w;
    w = 32'h0;
    foreach (got_tx[i]) w = {w[23:0], got_tx[i]};
    return w;
  endfunction

  initial begin
    int s;
    int base;
    mem[32'h0000_2004] = 32'h1234_5678;
    mem[32'h0000_FFFC] = 32'hCAFE_F00D;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cyc", 32'(wb.cyc), 32'h0);
    check("rst_stb", 32'(wb.stb), 32'h0);
    check("rst_we", 32'(wb.we), 32'h0);
    check("rst_adr", wb.adr, 32'h0);
    check("rst_dat_w", wb.dat_w, 32'h0);
    check("rst_sel", 32'(wb.sel), 32'hF);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Write
    do_write(32'h0000_1000, 32'hDEAD_BEEF);
    check("wr_busy", 32'(busy), 32'h1);
    wait_idle(100);
    check("wr_rsp_len", 32'(got_tx.size()), 32'h1);
    check("wr_rsp", got_word(), 32'h0000_004B);
    check("wr_mem", rd(32'h0000_1000), 32'hDEAD_BEEF);
    check("wr_busy_done", 32'(busy), 32'h0);

    // Read with a 3-cycle tx stall after two bytes
    base = acc_cnt;
    do_read(32'h0000_2004);
    for (int i = 0; i < 50 && acc_cnt < base + 2; i++) begin
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("stall_valid", 32'(tx_valid), 32'h1);
      check("stall_data", 32'(tx_data), 32'h56);
    end
    tx_ready = 1'b1;
    wait_idle(100);
    check("rd_rsp", got_word(), 32'h1234_5678);

    // Bad opcode
    s = cyc_starts;
    do_bad(8'h41);
    wait_idle(50);
    check("bad_rsp", got_word(), 32'h0000_003F);
    check("bad_no_cyc", 32'(cyc_starts), 32'(s));
    check("bad_busy", 32'(busy), 32'h0);

    // Responder that never acks, then a normal read
    ack_en = 1'b0;
    do_read(32'h0000_FFFC);
    wait_idle(TMO + 100);
    check("tmo_len", 32'(last_cyc_len), 32'd1024);
    check("tmo_rsp", got_word(), 32'h0000_0021);
    ack_en = 1'b1;
    do_read(32'h0000_FFFC);
    wait_idle(100);
    check("post_tmo_rsp", got_word(), 32'hCAFE_F00D);

    // Ack on the threshold cycle succeeds; one cycle later times out
    ack_delay = 1022;
    do_read(32'h0000_2004);
    wait_idle(TMO + 100);
    check("thr_len", 32'(last_cyc_len), 32'd1024);
    check("thr_rsp", got_word(), 32'h1234_5678);
    ack_delay = 1023;
    do_read(32'h0000_2004);
    wait_idle(TMO + 100);
    check("late_rsp", got_word(), 32'h0000_0021);

    // Byte injected during BUS
    ack_delay = 20;
    check("ovr_before", 32'(overrun), 32'h0);
    s = cyc_starts;
    do_write(32'h0000_3000, 32'h0BAD_CAFE);
    send_byte(8'h52);
    check("ovr_set", 32'(overrun), 32'h1);
    wait_idle(100);
    check("ovr_rsp", got_word(), 32'h0000_004B);
    check("ovr_sticky", 32'(overrun), 32'h1);
    repeat (5) @(posedge clk);
    #1;
    check("ovr_no_cmd", 32'(busy), 32'h0);
    check("ovr_one_cyc", 32'(cyc_starts), 32'(s + 1));
    check("ovr_mem", rd(32'h0000_3000), 32'h0BAD_CAFE);
    do_reset();
    check("ovr_cleared", 32'(overrun), 32'h0);
    ack_delay = 0;

    // Asynchronous reset mid-transfer
    ack_en = 1'b0;
    do_read(32'h0000_2004);
    repeat (3) @(posedge clk);
    #1;
    check("arst_cyc_before", 32'(wb.cyc), 32'h1);
    #3;
    reset = 1'b1;
    exp_bus.delete();
    exp_tx.delete();
    #1;
    check("arst_cyc", 32'(wb.cyc), 32'h0);
    check("arst_stb", 32'(wb.stb), 32'h0);
    check("arst_tx_valid", 32'(tx_valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    ack_en = 1'b1;
    do_write(32'h0000_1008, 32'h55AA_1234);
    wait_idle(100);
    check("arst_wr_rsp", got_word(), 32'h0000_004B);
    check("arst_wr_mem", rd(32'h0000_1008), 32'h55AA_1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wishbone_debug_master.md
Name: wishbone_debug_master

Overview:
Byte-stream-to-Wishbone bridge that acts as a bus initiator. A host drives it through the UART byte channel, and the bridge issues single classic Wishbone read or write cycles into the switch. It sits beside the CPU's IF and LSU masters as a third master, and gives external debug and load access to ROM, RAM and UART space. It is the initiator counterpart to the existing responder slaves.

Parameters:
TIMEOUT_CYCLES, 1024, maximum cycles cyc/stb stay asserted waiting for ack before the bridge aborts the transfer.
CNT_W, 11, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock; the single clock for the block.
reset  input  1  asynchronous, active-high reset.
rx_data  input  8  received byte.
rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
tx_data  output  8  byte to transmit.
tx_valid  output  1  tx_data is valid; held until accepted.
tx_ready  input  1  transmitter accepts the byte when tx_valid and tx_ready are both high.
wishbone  wishbone_if.master  —  uses cyc, stb, we, adr[31:0], sel[3:0], write data[31:0], read data[31:0], ack.
busy  output  1  high in any state other than IDLE.
overrun  output  1  sticky flag: a byte arrived while it could not be accepted; cleared only by reset.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - cyc, stb, we, tx_valid, busy and overrun go to 0; adr, write data, tx_data go to 0; sel goes to 4'hF.
  - State goes to IDLE and all counters clear.
  - A bus cycle in flight is abandoned; cyc/stb drop without waiting for ack.
- Command format (multi-byte fields big-endian, MSB first):
  - 'W' (0x57), A3 A2 A1 A0, D3 D2 D1 D0 → single write; response 0x4B ('K').
  - 'R' (0x52), A3 A2 A1 A0 → single read; response D3 D2 D1 D0.
  - Any other opcode → response 0x3F ('?'); no bus cycle.
- States: IDLE → ADDR → (DATA for writes) → BUS → RESP → IDLE.
  - IDLE: on rx_valid, decode the opcode. 'R'/'W' → ADDR with byte count 0. Other opcode → RESP with a one-byte '?' response.
  - ADDR: each rx_valid shifts a byte into adr. After the 4th byte, go to DATA for a write or BUS for a read.
  - DATA: each rx_valid shifts a byte into write data. After the 4th byte, go to BUS.
  - BUS:
    - cyc=stb=1 from the cycle after the last command byte; we=1 for writes; sel=4'hF; adr passed unaligned as received.
    - On ack, latch read data. cyc/stb/we are registered low on the following cycle, so the transfer completes in exactly one acked cycle.
    - The timeout counter increments every BUS cycle. When it reaches TIMEOUT_CYCLES without ack, drop cyc/stb and respond with the single byte 0x21 ('!') for both reads and writes.
    - An ack in the same cycle as the timeout threshold counts as success.
  - RESP:
    - tx_valid rises the cycle after entry. tx_data is stable while tx_valid && !tx_ready.
    - The next byte is presented the cycle after each accept.
    - After the last byte is accepted, tx_valid drops in that same registered update and state returns to IDLE.
    - Response lengths: read = 4 bytes, write = 1, error = 1.
- rx_valid arriving in BUS or RESP: the byte is dropped and overrun is set. No partial command is ever started from a dropped byte.
- ack outside the BUS state is ignored.
- No inter-byte timeout: a partially received command waits indefinitely; only reset aborts it.
- busy = (state != IDLE), registered.

Decomposition:
- Package dbg_bridge_pkg:
  - Opcode constants: OP_READ=8'h52, OP_WRITE=8'h57.
  - Response constants: RSP_OK=8'h4B, RSP_BADOP=8'h3F, RSP_TIMEOUT=8'h21.
  - State enum dbg_state_t {IDLE, ADDR, DATA, BUS, RESP}.
- A single module; no sub-module is warranted. The response serializer is a 2-bit index plus a 4-byte shift register within the FSM.

Test Plan:
- Write: bytes 57 00 00 10 00 DE AD BE EF → one cycle with we=1, adr=0x00001000, data=0xDEADBEEF, sel=F; after ack, tx emits 4B; busy returns to 0.
- Read with a RAM model preloaded 0x12345678 at 0x00002004: bytes 52 00 00 20 04 → cyc/stb the cycle after the last byte; tx emits 12 34 56 78 in order; tx_ready held low for 3 cycles mid-stream keeps tx_data stable.
- Bad opcode 0x41 → tx emits 3F; cyc never asserts; busy returns low.
- Slave that never acks, read of 0x0000FFFC → cyc/stb drop after exactly TIMEOUT_CYCLES cycles; tx emits 21; a following valid read succeeds.
- Byte injected during BUS → overrun=1 and stays set; the command completes normally; reset clears overrun.
- Reset asserted asynchronously while cyc=1 → cyc, stb and tx_valid are 0 immediately; after release, a fresh write 57… completes with 4B.
